// File: rtl/pipe_pkg.sv
// Shared constants and types for the 5-stage MIPS pipeline front end.
package pipe_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned RS_MSB   = 25;
  localparam int unsigned RS_LSB   = 21;
  localparam int unsigned RT_MSB   = 20;
  localparam int unsigned RT_LSB   = 16;

  localparam logic [XLEN-1:0] NOP      = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Per-cycle front-end mode; decoded combinationally, never stored.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } mode_e;

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: imem port, hazard inputs, IF/ID outputs and counters.
interface if_id_stage_if;
  import pipe_pkg::*;

  logic [XLEN-1:0]   imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              EX_MemRead;
  logic [REG_AW-1:0] EX_rt;
  logic              MEM_branch_taken;
  logic [XLEN-1:0]   MEM_branch_target;
  logic [XLEN-1:0]   ID_order;
  logic [XLEN-1:0]   ID_pc4;
  logic              ID_valid;
  logic              idex_bubble;
  logic              flush_idex;
  logic              flush_exmem;
  logic [XLEN-1:0]   stall_cnt;
  logic [XLEN-1:0]   flush_cnt;

  // Stage side
  modport master (
    output imem_addr, ID_order, ID_pc4, ID_valid,
           idex_bubble, flush_idex, flush_exmem, stall_cnt, flush_cnt,
    input  imem_rdata, EX_MemRead, EX_rt, MEM_branch_taken, MEM_branch_target
  );

  // Surrounding pipeline / memory side
  modport slave (
    input  imem_addr, ID_order, ID_pc4, ID_valid,
           idex_bubble, flush_idex, flush_exmem, stall_cnt, flush_cnt,
    output imem_rdata, EX_MemRead, EX_rt, MEM_branch_taken, MEM_branch_target
  );

endinterface

// File: rtl/if_id_stage_hazard_unit.sv
// Load-use hazard detect between the instruction in ID and a load in EX.
module hazard_unit
  import pipe_pkg::*;
(
  input  logic [XLEN-1:0]   ID_order,
  input  logic              ID_valid,
  input  logic              EX_MemRead,
  input  logic [REG_AW-1:0] EX_rt,
  output logic              hazard
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              unused_fields;

  assign rs = ID_order[RS_MSB:RS_LSB];
  assign rt = ID_order[RT_MSB:RT_LSB];
  assign unused_fields = ^{ID_order[31:26], ID_order[15:0]};

  // Bubbles never stall, and $0 is never a real dependency.
  assign hazard = ID_valid & EX_MemRead & (EX_rt != '0) &
                  ((EX_rt == rs) | (EX_rt == rt));

endmodule

// File: rtl/if_id_stage.sv
// PC register, instruction fetch and IF/ID register with load-use stall,
// branch redirect flush and saturating stall/flush event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP      = pipe_pkg::NOP
) (
  input  logic          clk,
  input  logic          rst,
  if_id_stage_if.master bus
);
  import pipe_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic            hazard;
  mode_e           mode;

  hazard_unit u_hazard (
    .ID_order   (bus.ID_order),
    .ID_valid   (bus.ID_valid),
    .EX_MemRead (bus.EX_MemRead),
    .EX_rt      (bus.EX_rt),
    .hazard     (hazard)
  );

  assign pc4           = pc + XLEN'(4);
  assign bus.imem_addr = pc;

  // Redirect has priority over a stall in the same cycle.
  always_comb begin
    mode = RUN;
    if (bus.MEM_branch_taken) begin
      mode = REDIRECT;
    end else if (hazard) begin
      mode = STALL;
    end
  end

  always_comb begin
    bus.idex_bubble = 1'b0;
    bus.flush_idex  = 1'b0;
    bus.flush_exmem = 1'b0;
    if (!rst) begin
      bus.idex_bubble = (mode == STALL);
      bus.flush_idex  = (mode == REDIRECT);
      bus.flush_exmem = (mode == REDIRECT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      bus.ID_order  <= NOP;
      bus.ID_pc4    <= '0;
      bus.ID_valid  <= 1'b0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      unique case (mode)
        REDIRECT: begin
          pc           <= bus.MEM_branch_target;
          bus.ID_order <= NOP;
          bus.ID_pc4   <= '0;
          bus.ID_valid <= 1'b0;
          if (bus.flush_cnt != '1) begin
            bus.flush_cnt <= bus.flush_cnt + XLEN'(1);
          end
        end
        STALL: begin
          if (bus.stall_cnt != '1) begin
            bus.stall_cnt <= bus.stall_cnt + XLEN'(1);
          end
        end
        default: begin
          pc           <= pc4;
          bus.ID_order <= bus.imem_rdata;
          bus.ID_pc4   <= pc4;
          bus.ID_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule
